// File: rtl/rv_regfile_sb.sv
// Dual-write-port integer register file with write-to-read bypass, busy scoreboard
// and a sequenced clear engine; NREG selects the RV32E (16) or RV32I (32) variant.
module rv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done,
    output logic            addr_err
);

    localparam int            IW     = $clog2(NREG);
    localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] reg_q [NREG];
    logic [XLEN-1:0] reg_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            addr_err_q, addr_err_d;
    logic            idle_s;
    logic            hit0_s, hit1_s;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_W);
    endfunction

    function automatic logic legal(input logic [AW-1:0] a);
        return in_range(a) && (a != {AW{1'b0}});
    endfunction

    // Port 1 (load return) is the younger write, so it wins over port 0 when forwarding.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
        logic [XLEN-1:0] v;
        v = {XLEN{1'b0}};
        if (legal(ra)) begin
            if ((BYPASS != 0) && idle_s && we1 && (wa1 == ra)) begin
                v = wd1;
            end else if ((BYPASS != 0) && idle_s && we0 && (wa0 == ra)) begin
                v = wd0;
            end else begin
                v = reg_q[ra[IW-1:0]];
            end
        end else begin
            v = {XLEN{1'b0}};
        end
        return v;
    endfunction

    assign idle_s = (state_q == ST_IDLE);

    // Combinational read and scoreboard lookup for both decode ports.
    always_comb begin
        rd1   = read_port(ra1);
        rd2   = read_port(ra2);
        busy1 = legal(ra1) ? busy_q[ra1[IW-1:0]] : 1'b0;
        busy2 = legal(ra2) ? busy_q[ra2[IW-1:0]] : 1'b0;
    end

    // Next-state: writes, scoreboard and clear sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reg_d      = reg_q;
        busy_d     = busy_q;
        addr_err_d = 1'b0;
        hit0_s     = 1'b0;
        hit1_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_err_d = (we0 && !in_range(wa0)) || (we1 && !in_range(wa1)) ||
                             (iss_v && !in_range(iss_rd));
                // Index 0 is skipped: x0 is never written and never busy.
                for (int i = 1; i < NREG; i++) begin
                    hit0_s = we0 && (wa0 == AW'(i));
                    hit1_s = we1 && (wa1 == AW'(i));
                    if (hit1_s) begin
                        reg_d[i] = wd1;
                    end else if (hit0_s) begin
                        reg_d[i] = wd0;
                    end else begin
                        reg_d[i] = reg_q[i];
                    end
                    busy_d[i] = (iss_v && (iss_rd == AW'(i))) ||
                                (busy_q[i] && !(hit0_s || hit1_s));
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {{(AW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_CLEAR: begin
                reg_d[cnt_q[IW-1:0]]  = {XLEN{1'b0}};
                busy_d[cnt_q[IW-1:0]] = 1'b0;
                cnt_d                 = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_A) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = {AW{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // State registers; asynchronous reset also aborts an in-progress clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {AW{1'b0}};
            busy_q     <= {NREG{1'b0}};
            addr_err_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
            reg_q      <= reg_d;
        end
    end

    assign clr_busy = (state_q != ST_IDLE);
    assign clr_done = (state_q == ST_DONE);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Randomized self-checking bench for rv_regfile_sb: a BYPASS=1 and a BYPASS=0 instance
// share stimulus and are compared against an array-based reference model.
module tb_rv_regfile_sb;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, iss_v, clr_req;
    logic [4:0]  wa0, wa1, ra1, ra2, iss_rd;
    logic [31:0] wd0, wd1;
    logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        busy1, busy2, clr_busy, clr_done, addr_err;
    logic        busy1_nb, busy2_nb, clr_busy_nb, clr_done_nb, addr_err_nb;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];
    int          m_phase;
    bit          m_err;
    string       p_tag = "";
    logic [31:0] p_exp;

    always #5 clk = ~clk;

    rv_regfile_sb #(.XLEN(32), .NREG(N), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
        .iss_v(iss_v), .iss_rd(iss_rd), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done), .addr_err(addr_err)
    );

    rv_regfile_sb #(.XLEN(32), .NREG(N), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb), .busy1(busy1_nb), .busy2(busy2_nb),
        .iss_v(iss_v), .iss_rd(iss_rd), .clr_req(clr_req),
        .clr_busy(clr_busy_nb), .clr_done(clr_done_nb), .addr_err(addr_err_nb)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ok_addr(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < N);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (!ok_addr(ra)) return 32'd0;
        if (byp && m_phase == 0 && we1 && wa1 == ra) return wd1;
        if (byp && m_phase == 0 && we0 && wa0 == ra) return wd0;
        return m_reg[ra];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] ra);
        return ok_addr(ra) ? 32'(m_busy[ra]) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_phase = 0;
        m_err   = 1'b0;
    endtask

    // m_phase: 0 idle, k in 1..N-1 clearing register k this cycle, N the done cycle.
    task automatic model_update();
        if (m_phase == 0) begin
            m_err = (we0 && int'(wa0) >= N) || (we1 && int'(wa1) >= N) ||
                    (iss_v && int'(iss_rd) >= N);
            if (we0 && ok_addr(wa0)) begin m_reg[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && ok_addr(wa1)) begin m_reg[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (iss_v && ok_addr(iss_rd)) m_busy[iss_rd] = 1'b1;
            if (clr_req) m_phase = 1;
        end else begin
            m_err = 1'b0;
            if (m_phase < N) begin
                m_reg[m_phase]  = 32'd0;
                m_busy[m_phase] = 1'b0;
                m_phase++;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("rd1", rd1, exp_rd(ra1, 1'b1));
        check_eq("rd2", rd2, exp_rd(ra2, 1'b1));
        check_eq("rd1_nobyp", rd1_nb, exp_rd(ra1, 1'b0));
        check_eq("rd2_nobyp", rd2_nb, exp_rd(ra2, 1'b0));
        check_eq("busy1", 32'(busy1), exp_busy(ra1));
        check_eq("busy2", 32'(busy2), exp_busy(ra2));
        check_eq("busy1_nobyp", 32'(busy1_nb), exp_busy(ra1));
        check_eq("busy2_nobyp", 32'(busy2_nb), exp_busy(ra2));
        check_eq("clr_busy", 32'(clr_busy), 32'(m_phase != 0));
        check_eq("clr_done", 32'(clr_done), 32'(m_phase == N));
        check_eq("addr_err", 32'(addr_err), 32'(m_err));
        check_eq("clr_busy_nobyp", 32'(clr_busy_nb), 32'(m_phase != 0));
        check_eq("clr_done_nobyp", 32'(clr_done_nb), 32'(m_phase == N));
        check_eq("addr_err_nobyp", 32'(addr_err_nb), 32'(m_err));
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
        iss_v = 1'b0; iss_rd = 5'd0; clr_req = 1'b0;
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    // Called at posedge+1 with inputs already driven; checks, then advances one edge.
    task automatic step();
        #2;
        check_outputs();
        if (p_tag != "") begin
            check_eq(p_tag, rd1, p_exp);
            p_tag = "";
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        check_outputs();
        #11;
        rst_n = 1'b1;

        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        step();
        idle_inputs(); ra1 = 5'd5; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234_5678;
        p_tag = "plan_read5"; p_exp = 32'hDEADBEEF;
        step();

        idle_inputs();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222; ra1 = 5'd7;
        p_tag = "plan_bypass_p1"; p_exp = 32'h22222222;
        step();
        idle_inputs(); ra1 = 5'd7;
        p_tag = "plan_stored_p1"; p_exp = 32'h22222222;
        step();

        idle_inputs(); iss_v = 1'b1; iss_rd = 5'd3;
        step();
        idle_inputs(); ra1 = 5'd3; iss_v = 1'b1; iss_rd = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5A5A5;
        step();
        idle_inputs(); ra1 = 5'd3; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0BAD_F00D;
        step();
        idle_inputs(); ra1 = 5'd3;
        step();

        idle_inputs(); we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hFFFF_FFFF;
        step();
        idle_inputs(); ra1 = 5'd20; ra2 = 5'd4;
        step();
        step();

        for (int i = 1; i < N; i++) begin
            idle_inputs(); we0 = 1'b1; wa0 = 5'(i); wd0 = $urandom | 32'd1;
            step();
        end
        idle_inputs(); clr_req = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            idle_inputs();
            we0 = 1'b1; wa0 = 5'($urandom_range(1, N - 1)); wd0 = $urandom;
            iss_v = 1'b1; iss_rd = 5'($urandom_range(0, 20)); clr_req = 1'b1;
            ra1 = wa0; ra2 = 5'($urandom_range(0, N - 1));
            step();
        end
        for (int i = 0; i < N; i++) begin
            idle_inputs(); ra1 = 5'(i); ra2 = 5'(N - 1 - i);
            p_tag = "plan_cleared"; p_exp = 32'd0;
            step();
        end

        for (int i = 1; i < N; i++) begin
            idle_inputs(); we1 = 1'b1; wa1 = 5'(i); wd1 = $urandom | 32'd1;
            iss_v = 1'b1; iss_rd = 5'(i);
            step();
        end
        idle_inputs(); clr_req = 1'b1;
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        ra1 = 5'd9; ra2 = 5'd15;
        check_outputs();
        #1;
        rst_n = 1'b1;
        for (int i = 1; i < N; i++) begin
            idle_inputs(); ra1 = 5'(i); ra2 = 5'(i);
            step();
        end

        for (int c = 0; c < 800; c++) begin
            we0 = 1'($urandom); wa0 = 5'($urandom_range(0, 20)); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 20)); wd1 = $urandom;
            iss_v = ($urandom_range(0, 2) == 0); iss_rd = 5'($urandom_range(0, 20));
            clr_req = ($urandom_range(0, 49) == 0);
            ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 20));
            ra2 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 20));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
